// File: rtl/d_memory_model.sv
// Behavioural data memory answering the load/store unit's memory controller
// handshake with a fixed, parameterised latency. Word-addressed array, full-word
// loads and stores, one outstanding request at a time.

package d_memory_pkg;
  localparam int REG_VAL_WIDTH       = 32;
  localparam int D_MEMORY_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } memory_op_t;
endpackage

module d_memory_model
  import d_memory_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 3,
  parameter string INIT_FILE = ""
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memory_req_valid,
  input  memory_op_t                     memory_req_op,
  input  logic [D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
  input  logic [REG_VAL_WIDTH-1:0]       memory_req_data,
  output logic                           memory_ready,
  output logic                           memory_ack,
  output logic [REG_VAL_WIDTH-1:0]       memory_data_return
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                   state, state_d;
  logic [3:0]               cnt, cnt_d;
  logic [REG_VAL_WIDTH-1:0] mem [DEPTH];
  logic [REG_VAL_WIDTH-1:0] resp_q;
  logic [IDX_W-1:0]         idx;
  logic                     accept;
  logic                     unused_addr_bits;

  // Byte offset and bits above the word index are ignored: addresses wrap.
  assign idx              = memory_req_address[IDX_W+1:2];
  assign unused_addr_bits = ^{memory_req_address[D_MEMORY_ADDR_WIDTH-1:IDX_W+2],
                              memory_req_address[1:0]};

  // memory_ready is the registered image of "state is IDLE"
  assign accept = memory_req_valid && memory_ready;

  assign memory_data_return = resp_q;

  // Next-state and latency counter logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; ready/ack are decoded from next state so both leave flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      memory_ready <= 1'b1;
      memory_ack   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      memory_ready <= (state_d == S_IDLE);
      memory_ack   <= (state_d == S_RESP);
    end
  end

  // Load data is captured at acceptance and held until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= '0;
    end else if (accept && memory_req_op == MEM_LOAD) begin
      resp_q <= mem[idx];
    end
  end

  // Store write at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && memory_req_op == MEM_STORE) begin
      mem[idx] <= memory_req_data;
    end
  end

endmodule

// File: tb/tb_d_memory_model.sv
// Self-checking bench for d_memory_model: three instances (LATENCY 3, 1, 15)
// driven against a word-indexed reference memory and a cycle-count timing model.

module tb_d_memory_model;
  import d_memory_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid [3];
  memory_op_t  op    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        ack   [3];
  logic [31:0] ret   [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [int];
  logic [31:0] last_ret [3];
  int          written [$];

  always #5 clk = ~clk;

  d_memory_model #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .memory_req_valid(valid[0]), .memory_req_op(op[0]),
    .memory_req_address(addr[0]), .memory_req_data(wdata[0]),
    .memory_ready(ready[0]), .memory_ack(ack[0]), .memory_data_return(ret[0]));

  d_memory_model #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .memory_req_valid(valid[1]), .memory_req_op(op[1]),
    .memory_req_address(addr[1]), .memory_req_data(wdata[1]),
    .memory_ready(ready[1]), .memory_ack(ack[1]), .memory_data_return(ret[1]));

  d_memory_model #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .memory_req_valid(valid[2]), .memory_req_op(op[2]),
    .memory_req_address(addr[2]), .memory_req_data(wdata[2]),
    .memory_ready(ready[2]), .memory_ack(ack[2]), .memory_data_return(ret[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Reference word index: address modulo DEPTH words, byte offset dropped.
  function automatic int key(input int d, input logic [31:0] a);
    return d * DEPTH + int'((a / 4) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic xact(input int d, input memory_op_t o, input logic [31:0] a,
                      input logic [31:0] wd, output time t_acc);
    int          lat;
    int          n;
    logic [31:0] exp;
    lat = lat_of(d);
    n   = 0;
    exp = last_ret[d];
    while (ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", 32'(ready[d]), 32'd1);
    valid[d] = 1'b1; op[d] = o; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    t_acc = $time;
    if (o == MEM_STORE) model[key(d, a)] = wd;
    else if (o == MEM_LOAD) exp = model.exists(key(d, a)) ? model[key(d, a)] : 'x;
    @(negedge clk);
    valid[d] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      check("ack_timing", 32'(ack[d]), 32'(k == lat));
      check("ready_low_busy", 32'(ready[d]), 32'd0);
      if (k == lat) begin
        last_ret[d] = exp;
        check("data_return", ret[d], last_ret[d]);
      end
    end
    @(negedge clk);
    check("ready_after_ack", 32'(ready[d]), 32'd1);
    check("ack_single", 32'(ack[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time         t0, t1;
    int          n_ack;
    logic [31:0] a, exp;
    int          w;

    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; op[d] = MEM_NOP; addr[d] = '0; wdata[d] = '0; last_ret[d] = '0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", 32'(ready[d]), 32'd1);
      check("rst_ack",   32'(ack[d]),   32'd0);
      check("rst_data",  ret[d],        32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Store/load round trip with back-to-back spacing LATENCY+1
    xact(0, MEM_STORE, 32'h40, 32'hDEADBEEF, t0);
    xact(0, MEM_LOAD,  32'h40, 32'h0, t1);
    check("b2b_spacing_l3", 32'((t1 - t0) / 10), 32'd4);

    // Byte offset and aliasing above DEPTH
    xact(0, MEM_STORE, 32'h40, 32'h12345678, t0);
    xact(0, MEM_LOAD,  32'h43, 32'h0, t0);
    xact(0, MEM_LOAD,  32'h40 + 4 * DEPTH, 32'h0, t0);

    // Request held while busy is not accepted until IDLE, and acked once
    exp = model[key(0, 32'h40)];
    valid[0] = 1'b1; op[0] = MEM_LOAD; addr[0] = 32'h40;
    @(posedge clk);
    @(negedge clk);
    op[0] = MEM_STORE; addr[0] = 32'h80; wdata[0] = 32'hAAAA5555;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      check("hold_ack_timing", 32'(ack[0]), 32'(k == 3));
      check("hold_ready_low", 32'(ready[0]), 32'd0);
    end
    last_ret[0] = exp;
    check("hold_load_data", ret[0], exp);
    @(negedge clk);
    check("hold_ready_back", 32'(ready[0]), 32'd1);
    @(posedge clk);
    model[key(0, 32'h80)] = 32'hAAAA5555;
    @(negedge clk);
    valid[0] = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (ack[0] === 1'b1) n_ack++;
    end
    check("hold_one_ack", 32'(n_ack), 32'd1);
    xact(0, MEM_LOAD, 32'h80, 32'h0, t0);

    // Reset mid-WAIT: no ack, store already committed survives
    valid[0] = 1'b1; op[0] = MEM_STORE; addr[0] = 32'h100; wdata[0] = 32'h55AA1234;
    @(posedge clk);
    model[key(0, 32'h100)] = 32'h55AA1234;
    @(negedge clk);
    valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) last_ret[d] = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(ack[0]), 32'd0);
      check("midrst_ready_idle", 32'(ready[0]), 32'd1);
    end
    xact(0, MEM_LOAD, 32'h100, 32'h0, t0);

    // Randomised mix of stores, loads of written words, and undefined ops
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4 || written.size() == 0) begin
        w = $urandom_range(0, DEPTH - 1);
        a = ($urandom & 32'hFFFF_F003) | (w << 2);
        written.push_back(w);
        xact(0, MEM_STORE, a, $urandom, t0);
      end else if (r < 8) begin
        w = written[$urandom_range(0, written.size() - 1)];
        a = ($urandom & 32'hFFFF_F003) | (w << 2);
        xact(0, MEM_LOAD, a, 32'h0, t0);
      end else begin
        xact(0, memory_op_t'(2'b11), $urandom, $urandom, t0);
      end
    end

    // LATENCY=1 back-to-back alternating store/load
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      a = 32'(i * 4);
      xact(1, MEM_STORE, a, $urandom, t1);
      if (i > 0) check("b2b_spacing_l1", 32'((t1 - t0) / 10), 32'd2);
      xact(1, MEM_LOAD, a, 32'h0, t0);
      check("b2b_spacing_l1", 32'((t0 - t1) / 10), 32'd2);
    end

    // LATENCY=15 single store and load
    xact(2, MEM_STORE, 32'h3C, 32'hCAFEF00D, t0);
    xact(2, MEM_LOAD,  32'h3C, 32'h0, t1);
    check("b2b_spacing_l15", 32'((t1 - t0) / 10), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
